// File: rtl/xbar_scheduler_if.sv
// Scheduler <-> crossbar datapath bundle.
// master = scheduler side, slave = input blocks / output ports.
interface xbar_scheduler_if #(
  parameter int PORTS = 8,
  parameter int SEL_W = 3
);
  logic [PORTS-1:0]       req;
  logic [PORTS*SEL_W-1:0] dest;
  logic [PORTS-1:0]       dest_ready;
  logic [SEL_W-1:0]       mux_sel;
  logic                   sw_valid;
  logic [SEL_W-1:0]       sw_dest;
  logic [PORTS-1:0]       ack;
  logic                   abort;
  logic                   busy;

  modport master (
    input  req,
    input  dest,
    input  dest_ready,
    output mux_sel,
    output sw_valid,
    output sw_dest,
    output ack,
    output abort,
    output busy
  );

  modport slave (
    output req,
    output dest,
    output dest_ready,
    input  mux_sel,
    input  sw_valid,
    input  sw_dest,
    input  ack,
    input  abort,
    input  busy
  );
endinterface

// File: rtl/xbar_scheduler.sv
// Round-robin crossbar scheduler: grants one eligible input,
// holds it for a fixed transfer window, then acks or aborts.
module xbar_scheduler #(
  parameter int PORTS       = 8,
  parameter int SEL_W       = 3,
  parameter int XFER_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  xbar_scheduler_if.master bus
);
  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  localparam logic [7:0] CNT_INIT =
    8'(XFER_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST_RST =
    SEL_W'(PORTS - 1);

  state_t           state_q;
  logic [7:0]       cnt_q;
  logic [SEL_W-1:0] last_q;
  logic [SEL_W-1:0] mux_sel_q;
  logic [SEL_W-1:0] sw_dest_q;
  logic             sw_valid_q;
  logic             abort_q;
  logic             busy_q;
  logic [PORTS-1:0] ack_q;

  logic [PORTS-1:0] elig;
  logic [SEL_W-1:0] gnt;
  logic [SEL_W-1:0] idx;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_dest;

  always_comb begin
    elig = '0;
    for (int i = 0; i < PORTS; i++) begin
      elig[i] = bus.req[i] &
        bus.dest_ready[bus.dest[i*SEL_W +: SEL_W]];
    end
  end

  // First eligible port searching upward from last+1.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = 1; k <= PORTS; k++) begin
      idx = SEL_W'((int'(last_q) + k) % PORTS);
      if (!gnt_vld && elig[idx]) begin
        gnt     = idx;
        gnt_vld = 1'b1;
      end
    end
  end

  assign gnt_dest = bus.dest[gnt*SEL_W +: SEL_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= LAST_RST;
      mux_sel_q  <= '0;
      sw_dest_q  <= '0;
      sw_valid_q <= 1'b0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= '0;
    end else begin
      ack_q   <= '0;
      abort_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            mux_sel_q  <= gnt;
            sw_dest_q  <= gnt_dest;
            sw_valid_q <= 1'b1;
            cnt_q      <= CNT_INIT;
            busy_q     <= 1'b1;
            state_q    <= XFER;
          end
        end
        XFER: begin
          // Abort wins over completion.
          if (!bus.req[mux_sel_q]) begin
            sw_valid_q <= 1'b0;
            abort_q    <= 1'b1;
            last_q     <= mux_sel_q;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else if (cnt_q == 8'd0) begin
            sw_valid_q       <= 1'b0;
            ack_q[mux_sel_q] <= 1'b1;
            last_q           <= mux_sel_q;
            state_q          <= DONE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mux_sel  = mux_sel_q;
  assign bus.sw_dest  = sw_dest_q;
  assign bus.sw_valid = sw_valid_q;
  assign bus.ack      = ack_q;
  assign bus.abort    = abort_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_xbar_scheduler.sv
// Directed bench for xbar_scheduler.
// Second instance covers XFER_CYCLES=1.
module tb_xbar_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xbar_scheduler_if #(.PORTS(8), .SEL_W(3)) i0 ();
  xbar_scheduler_if #(.PORTS(8), .SEL_W(3)) i1 ();

  xbar_scheduler #(
    .PORTS(8), .SEL_W(3), .XFER_CYCLES(16)
  ) dut0 (.clk(clk), .rst(rst), .bus(i0));

  xbar_scheduler #(
    .PORTS(8), .SEL_W(3), .XFER_CYCLES(1)
  ) dut1 (.clk(clk), .rst(rst), .bus(i1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i0.req = '0; i0.dest = '0; i0.dest_ready = '0;
    i1.req = '0; i1.dest = '0; i1.dest_ready = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_sv(input logic lvl,
                         output int n);
    n = 0;
    while (i0.sw_valid !== lvl && n < 64) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    #1;
    tests++;
    if ({i0.mux_sel, i0.sw_valid, i0.sw_dest, i0.ack,
         i0.abort, i0.busy} !== '0) begin
      fails++;
      $display("FAIL reset_outs: mux=%0d v=%b d=%0d ack=%h ab=%b busy=%b, want all 0",
        i0.mux_sel, i0.sw_valid, i0.sw_dest, i0.ack,
        i0.abort, i0.busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int n;
    do_reset();
    i0.dest[2*3 +: 3] = 3'd5;
    i0.dest_ready = 8'hFF;
    i0.req = 8'h04;
    wait_sv(1'b1, n);
    tests++;
    if (n >= 64) begin
      fails++;
      $display("FAIL single_grant: timeout, want sw_valid");
    end
    tests++;
    if (i0.mux_sel !== 3'd2 || i0.sw_dest !== 3'd5) begin
      fails++;
      $display("FAIL single_sel: mux=%0d dest=%0d want 2/5",
        i0.mux_sel, i0.sw_dest);
    end
    wait_sv(1'b0, n);
    tests++;
    if (n !== 16) begin
      fails++;
      $display("FAIL single_len: %0d cycles want 16", n);
    end
    tests++;
    if (i0.ack !== 8'h04 || i0.busy !== 1'b1) begin
      fails++;
      $display("FAIL single_ack: ack=%h busy=%b want 04/1",
        i0.ack, i0.busy);
    end
    i0.req = '0;
    step();
    tests++;
    if (i0.ack !== 8'h00 || i0.busy !== 1'b0) begin
      fails++;
      $display("FAIL single_end: ack=%h busy=%b want 00/0",
        i0.ack, i0.busy);
    end
  endtask

  task automatic test_round_robin();
    int n;
    int start;
    int prev;
    do_reset();
    i0.dest_ready = 8'hFF;
    i0.req = 8'hFF;
    prev = 0;
    for (int k = 0; k < 9; k++) begin
      wait_sv(1'b1, n);
      start = cyc;
      tests++;
      if (n >= 64 || i0.mux_sel !== 3'(k % 8)) begin
        fails++;
        $display("FAIL rr_order[%0d]: mux=%0d want %0d",
          k, i0.mux_sel, k % 8);
      end
      if (k > 0) begin
        tests++;
        if (start - prev !== 18) begin
          fails++;
          $display("FAIL rr_gap[%0d]: %0d want 18",
            k, start - prev);
        end
      end
      prev = start;
      wait_sv(1'b0, n);
    end
    i0.req = '0;
  endtask

  task automatic test_dest_block();
    int   n;
    logic seen;
    do_reset();
    i0.dest[0 +: 3] = 3'd4;
    i0.dest[3 +: 3] = 3'd6;
    i0.dest_ready = 8'hEF;
    i0.req = 8'h03;
    wait_sv(1'b1, n);
    tests++;
    if (n >= 64 || i0.mux_sel !== 3'd1 ||
        i0.sw_dest !== 3'd6) begin
      fails++;
      $display("FAIL blk_first: mux=%0d dest=%0d want 1/6",
        i0.mux_sel, i0.sw_dest);
    end
    wait_sv(1'b0, n);
    tests++;
    if (i0.ack !== 8'h02) begin
      fails++;
      $display("FAIL blk_ack1: ack=%h want 02", i0.ack);
    end
    i0.req = 8'h01;
    seen = 1'b0;
    repeat (10) begin
      step();
      seen |= i0.sw_valid;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL blk_hold: sw_valid=%b want 0", seen);
    end
    i0.dest_ready = 8'hFF;
    wait_sv(1'b1, n);
    tests++;
    if (n >= 64 || i0.mux_sel !== 3'd0 ||
        i0.sw_dest !== 3'd4) begin
      fails++;
      $display("FAIL blk_second: mux=%0d dest=%0d want 0/4",
        i0.mux_sel, i0.sw_dest);
    end
    wait_sv(1'b0, n);
    i0.req = '0;
    step();
  endtask

  task automatic test_abort();
    int n;
    do_reset();
    i0.dest_ready = 8'hFF;
    i0.req = 8'h08;
    wait_sv(1'b1, n);
    repeat (4) step();
    tests++;
    if (i0.sw_valid !== 1'b1 || i0.mux_sel !== 3'd3) begin
      fails++;
      $display("FAIL abort_pre: v=%b mux=%0d want 1/3",
        i0.sw_valid, i0.mux_sel);
    end
    i0.req = '0;
    step();
    tests++;
    if (i0.sw_valid !== 1'b0 || i0.abort !== 1'b1 ||
        i0.ack !== 8'h00) begin
      fails++;
      $display("FAIL abort_pulse: v=%b ab=%b ack=%h want 0/1/00",
        i0.sw_valid, i0.abort, i0.ack);
    end
    step();
    tests++;
    if (i0.abort !== 1'b0 || i0.ack !== 8'h00) begin
      fails++;
      $display("FAIL abort_clear: ab=%b ack=%h want 0/00",
        i0.abort, i0.ack);
    end
    i0.req = 8'h18;
    wait_sv(1'b1, n);
    tests++;
    if (n >= 64 || i0.mux_sel !== 3'd4) begin
      fails++;
      $display("FAIL abort_next: mux=%0d want 4", i0.mux_sel);
    end
    i0.req = '0;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    i0.dest[5*3 +: 3] = 3'd3;
    i0.dest_ready = 8'hFF;
    i0.req = 8'h20;
    wait_sv(1'b1, n);
    tests++;
    if (n >= 64 || i0.mux_sel !== 3'd5 ||
        i0.sw_dest !== 3'd3) begin
      fails++;
      $display("FAIL rmid_grant: mux=%0d dest=%0d want 5/3",
        i0.mux_sel, i0.sw_dest);
    end
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({i0.mux_sel, i0.sw_valid, i0.sw_dest, i0.ack,
         i0.abort, i0.busy} !== '0) begin
      fails++;
      $display("FAIL rmid_async: mux=%0d v=%b d=%0d ack=%h ab=%b busy=%b, want all 0",
        i0.mux_sel, i0.sw_valid, i0.sw_dest, i0.ack,
        i0.abort, i0.busy);
    end
    i0.req = 8'h81;
    step();
    rst = 1'b0;
    wait_sv(1'b1, n);
    tests++;
    if (n >= 64 || i0.mux_sel !== 3'd0) begin
      fails++;
      $display("FAIL rmid_after: mux=%0d want 0", i0.mux_sel);
    end
    i0.req = '0;
    step();
    step();
  endtask

  task automatic test_edge_xfer1();
    int n;
    do_reset();
    i1.dest_ready = 8'hFF;
    i1.req = 8'h80;
    n = 0;
    while (i1.sw_valid !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    tests++;
    if (n >= 64 || i1.mux_sel !== 3'd7) begin
      fails++;
      $display("FAIL x1_grant: mux=%0d want 7", i1.mux_sel);
    end
    step();
    tests++;
    if (i1.sw_valid !== 1'b0 || i1.ack !== 8'h80) begin
      fails++;
      $display("FAIL x1_ack: v=%b ack=%h want 0/80",
        i1.sw_valid, i1.ack);
    end
    i1.req = '0;
    step();
    tests++;
    if (i1.ack !== 8'h00 || i1.sw_valid !== 1'b0) begin
      fails++;
      $display("FAIL x1_end: v=%b ack=%h want 0/00",
        i1.sw_valid, i1.ack);
    end
  endtask

  initial begin
    i0.req = '0; i0.dest = '0; i0.dest_ready = '0;
    i1.req = '0; i1.dest = '0; i1.dest_ready = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_dest_block();
    test_abort();
    test_reset_mid();
    test_edge_xfer1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
